// File: rtl/branch_pred_gshare.sv
// Gshare/bimodal branch direction predictor: a table of saturating counters
// indexed by a folded PC, optionally XORed with global history.
module branch_pred_gshare #(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 8,
  parameter int unsigned MODE     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_past,
  input  logic        taken,
  input  logic        pred_past,
  input  logic        vld,
  output logic        predict_take,
  output logic        init_busy,
  output logic [31:0] resolve_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned DEPTH   = 1 << IDX_BITS;
  localparam int unsigned NSL     = (32 + IDX_BITS - 1) / IDX_BITS;
  localparam int unsigned PW      = NSL * IDX_BITS;
  localparam int unsigned GHR_W   = (GHR_BITS == 0) ? 1 : GHR_BITS;
  localparam bit          USE_GHR = (MODE == 1) && (GHR_BITS > 0);

  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic                walk_en, upd_en;
  logic [IDX_BITS-1:0] walk_q;
  logic [GHR_W-1:0]    ghr;
  logic [31:0]         resolve_q, mispred_q;
  logic [CTR_BITS-1:0] ctr_mem [DEPTH];

  // PC folding: XOR of IDX_BITS-wide slices, top slice zero-padded
  logic [PW-1:0]       pad_cur, pad_past;
  logic [IDX_BITS-1:0] acc_cur  [NSL+1];
  logic [IDX_BITS-1:0] acc_past [NSL+1];

  assign pad_cur     = PW'(pc_cur);
  assign pad_past    = PW'(pc_past);
  assign acc_cur[0]  = '0;
  assign acc_past[0] = '0;

  for (genvar s = 0; s < NSL; s++) begin : g_fold
    assign acc_cur[s+1]  = acc_cur[s]  ^ pad_cur[s*IDX_BITS +: IDX_BITS];
    assign acc_past[s+1] = acc_past[s] ^ pad_past[s*IDX_BITS +: IDX_BITS];
  end

  logic [IDX_BITS-1:0] ghr_ext, lookup_idx, upd_idx;
  logic [CTR_BITS-1:0] ctr_old, ctr_new;

  assign ghr_ext    = USE_GHR ? IDX_BITS'(ghr) : '0;
  assign lookup_idx = acc_cur[NSL]  ^ ghr_ext;
  assign upd_idx    = acc_past[NSL] ^ ghr_ext;

  // Saturating counter step for the resolving branch
  always_comb begin
    ctr_old = ctr_mem[upd_idx];
    ctr_new = ctr_old;
    if (taken) begin
      if (ctr_old != CTR_MAX) ctr_new = ctr_old + 1'b1;
    end else begin
      if (ctr_old != '0) ctr_new = ctr_old - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (walk_q == IDX_LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    walk_en   = 1'b0;
    upd_en    = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      INIT: begin
        walk_en   = 1'b1;
        init_busy = 1'b1;
      end
      RUN:     upd_en = vld;
      default: init_busy = 1'b1;
    endcase
  end

  // Table array carries no reset; the INIT walk defines its contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (walk_en)     ctr_mem[walk_q]  <= CTR_WEAK;
      else if (upd_en) ctr_mem[upd_idx] <= ctr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_q       <= '0;
      ghr          <= '0;
      resolve_q    <= '0;
      mispred_q    <= '0;
      predict_take <= 1'b1;
    end else begin
      if (walk_en) walk_q <= walk_q + 1'b1;
      predict_take <= walk_en ? CTR_WEAK[CTR_BITS-1] : ctr_mem[lookup_idx][CTR_BITS-1];
      if (upd_en) begin
        if (GHR_BITS > 0) ghr <= GHR_W'({ghr, taken});
        if (resolve_q != 32'hFFFF_FFFF) resolve_q <= resolve_q + 32'd1;
        if ((taken != pred_past) && (mispred_q != 32'hFFFF_FFFF))
          mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign resolve_cnt = resolve_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Directed bench for branch_pred_gshare: default gshare instance plus a small
// bimodal instance; every expectation is a hand-computed constant.
module tb_branch_pred_gshare;

  logic        clk = 1'b0;
  logic        rst, taken, pred_past, vld;
  logic [31:0] pc_cur, pc_past;
  logic        predict_take, init_busy;
  logic [31:0] resolve_cnt, mispred_cnt;

  logic        rst0, taken0, pred_past0, vld0;
  logic [31:0] pc_cur0, pc_past0;
  logic        predict_take0, init_busy0;
  logic [31:0] resolve_cnt0, mispred_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pred_gshare dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_past(pc_past), .taken(taken),
    .pred_past(pred_past), .vld(vld), .predict_take(predict_take),
    .init_busy(init_busy), .resolve_cnt(resolve_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_pred_gshare #(.IDX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst0), .pc_cur(pc_cur0), .pc_past(pc_past0), .taken(taken0),
    .pred_past(pred_past0), .vld(vld0), .predict_take(predict_take0),
    .init_busy(init_busy0), .resolve_cnt(resolve_cnt0), .mispred_cnt(mispred_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd256);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [9:0]  t_vec, mis_vec;
  logic [7:0]  exp_g [16];
  int          n;

  initial begin
    rst = 1'b1; vld = 1'b1; taken = 1'b1; pred_past = 1'b0;
    pc_cur = 32'hCAFE_0123; pc_past = 32'h0000_0044;
    rst0 = 1'b1; vld0 = 1'b0; taken0 = 1'b0; pred_past0 = 1'b0;
    pc_cur0 = '0; pc_past0 = '0;

    // Reset state, with vld held high through the walk
    tick();
    chk("rst_predict", 32'(predict_take), 32'd1);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_resolve", resolve_cnt, 32'd0);
    chk("rst_mispred", mispred_cnt, 32'd0);

    rst = 1'b0;
    repeat (100) tick();
    chk("walk_addr_100", 32'(dut.walk_q), 32'd100);
    chk("busy_mid_walk", 32'(init_busy), 32'd1);
    chk("predict_mid_walk", 32'(predict_take), 32'd1);

    // Reset mid-walk restarts the full 256-cycle walk
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin
      tick();
      n++;
    end
    vld = 1'b0;
    chk("walk_len_after_rst", 32'(n), 32'd256);
    chk("init_ghr", 32'(dut.ghr), 32'd0);
    chk("init_resolve", resolve_cnt, 32'd0);
    chk("init_mispred", mispred_cnt, 32'd0);
    chk("init_last_predict", 32'(predict_take), 32'd1);

    // Freshly walked table predicts taken everywhere
    pc_cur = 32'h1234_5678;
    tick();
    chk("idle_predict_a", 32'(predict_take), 32'd1);
    pc_cur = 32'hDEAD_BEEF;
    tick();
    chk("idle_predict_b", 32'(predict_take), 32'd1);

    // Same-cycle lookup and update on one index returns the old counter
    pc_cur = 32'h20; pc_past = 32'h20; vld = 1'b1; taken = 1'b0; pred_past = 1'b1;
    tick();
    chk("same_cycle_old", 32'(predict_take), 32'd1);
    vld = 1'b0;
    tick();
    chk("same_cycle_next", 32'(predict_take), 32'd0);
    chk("same_cycle_resolve", resolve_cnt, 32'd1);
    chk("same_cycle_mispred", mispred_cnt, 32'd1);

    // Statistics: 10 resolutions, 4 mispredicted
    do_reset("walk_len_stats");
    t_vec   = 10'b1101_0011_10;
    mis_vec = 10'b0100_1000_11;
    for (int i = 0; i < 10; i++) begin
      vld = 1'b1;
      pc_past = 32'h40 + 32'(i * 4);
      taken = t_vec[i];
      pred_past = t_vec[i] ^ mis_vec[i];
      tick();
    end
    vld = 1'b0;
    tick();
    chk("stats_resolve", resolve_cnt, 32'd10);
    chk("stats_mispred", mispred_cnt, 32'd4);

    // Preload statistics near saturation
    force dut.resolve_q = 32'hFFFF_FFFD;
    force dut.mispred_q = 32'hFFFF_FFFE;
    #1;
    release dut.resolve_q;
    release dut.mispred_q;
    vld = 1'b1; taken = 1'b1; pred_past = 1'b0; pc_past = 32'h80;
    tick();
    chk("sat_resolve_step", resolve_cnt, 32'hFFFF_FFFE);
    chk("sat_mispred_step", mispred_cnt, 32'hFFFF_FFFF);
    repeat (3) tick();
    vld = 1'b0;
    tick();
    chk("sat_resolve", resolve_cnt, 32'hFFFF_FFFF);
    chk("sat_mispred", mispred_cnt, 32'hFFFF_FFFF);

    // Gshare: alternating history at pc 0x100 (fold = 0x01)
    do_reset("walk_len_gshare");
    exp_g = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2A, 8'h55, 8'hAA,
              8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
    pc_past = 32'h100; pred_past = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vld = 1'b1;
      taken = (k % 2 == 0);
      tick();
      chk($sformatf("ghr_step_%0d", k), 32'(dut.ghr), 32'(exp_g[k]));
    end
    vld = 1'b0;
    chk("ctr_idx_ab", 32'(dut.ctr_mem[8'hAB]), 32'd3);
    chk("ctr_idx_54", 32'(dut.ctr_mem[8'h54]), 32'd0);
    pc_cur = 32'h100;
    tick();
    chk("gshare_pred_hist_aa", 32'(predict_take), 32'd1);
    vld = 1'b1; taken = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    chk("gshare_pred_hist_55", 32'(predict_take), 32'd0);
    vld = 1'b1; taken = 1'b0;
    tick();
    vld = 1'b0;
    tick();
    chk("gshare_pred_hist_aa2", 32'(predict_take), 32'd1);

    // Bimodal instance: history must not affect the index
    rst0 = 1'b0;
    n = 0;
    while (init_busy0 && n < 100) begin
      tick();
      n++;
    end
    chk("bimodal_walk_len", 32'(n), 32'd16);
    vld0 = 1'b1; pc_past0 = 32'h3; taken0 = 1'b1;
    tick();
    pc_past0 = 32'h10; taken0 = 1'b0;
    tick();
    chk("bimodal_ctr_1", 32'(dut0.ctr_mem[1]), 32'd1);
    tick();
    chk("bimodal_ctr_0", 32'(dut0.ctr_mem[1]), 32'd0);
    tick();
    chk("bimodal_ctr_sat0", 32'(dut0.ctr_mem[1]), 32'd0);
    vld0 = 1'b0;
    chk("bimodal_ghr", 32'(dut0.ghr), 32'h8);
    pc_cur0 = 32'h10;
    tick();
    chk("bimodal_pred_10", 32'(predict_take0), 32'd0);
    pc_cur0 = 32'h3;
    tick();
    chk("bimodal_pred_3", 32'(predict_take0), 32'd1);
    chk("bimodal_resolve", resolve_cnt0, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_gshare.md
BRANCH_PRED_GSHARE -- requirements
Module: branch_pred_gshare

Interface
REQ-001 Parameter IDX_BITS, default 8, table index width; table depth is 2^IDX_BITS; legal range 4..12.
REQ-002 Parameter CTR_BITS, default 2, saturating counter width; legal range 1..4.
REQ-003 Parameter GHR_BITS, default 8, global history length; legal range 0..IDX_BITS.
REQ-004 Parameter MODE, default 1, index mode; 0 = bimodal (history ignored), 1 = gshare.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 pc_cur  input  32  PC of the branch in instruction fetch (lookup address).
REQ-008 pc_past  input  32  PC of the branch resolving in Execute (update address).
REQ-009 taken  input  1  resolved direction of the Execute branch.
REQ-010 pred_past  input  1  prediction made earlier for the Execute branch.
REQ-011 vld  input  1  Execute branch valid; qualifies taken, pred_past and pc_past.
REQ-012 predict_take  output  1  registered prediction for pc_cur.
REQ-013 init_busy  output  1  table initialisation walk in progress.
REQ-014 resolve_cnt  output  32  count of accepted resolutions.
REQ-015 mispred_cnt  output  32  count of accepted resolutions where taken != pred_past.

Function
REQ-016 fold(pc) SHALL be the XOR of consecutive IDX_BITS-wide slices of pc[31:0], starting at bit 0; the top partial slice is zero-extended.
REQ-017 Lookup index SHALL be fold(pc_cur) XOR zero-extended ghr when MODE=1, and fold(pc_cur) when MODE=0 or GHR_BITS=0.
REQ-018 Update index SHALL be formed the same way from pc_past and the ghr value present in the same cycle.
REQ-019 Table entries SHALL be CTR_BITS-wide unsigned counters; the weakly-taken value W = 2^(CTR_BITS-1).
REQ-020 The block SHALL have two states, INIT and RUN: INIT writes W to one entry per cycle at addresses 0..2^IDX_BITS-1 ascending, then moves to RUN after the last address.
REQ-021 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-022 In INIT, vld SHALL be ignored; no counter, ghr or statistics update occurs.
REQ-023 In RUN, an accepted update (vld=1) SHALL increment the indexed counter when taken=1 and decrement it when taken=0, saturating at 2^CTR_BITS-1 and 0.
REQ-024 An accepted update SHALL shift taken into ghr LSB and discard the MSB; ghr is unchanged when vld=0.
REQ-025 predict_take SHALL be registered with 1-cycle latency: the value after edge N equals the MSB of the counter indexed by pc_cur and ghr sampled before edge N.
REQ-026 A same-cycle lookup and update to the same index SHALL return the pre-update counter value, with no bypass.
REQ-027 In INIT, predict_take SHALL register 1, the MSB of W.
REQ-028 An accepted update SHALL increment resolve_cnt, and also mispred_cnt when taken != pred_past; both saturate at 32'hFFFF_FFFF.
REQ-029 A counter, ghr and statistics update occurring in the same cycle SHALL all use pre-edge values.

Reset
REQ-030 rst=1 at an edge SHALL force state INIT, walk address 0, ghr 0, resolve_cnt 0, mispred_cnt 0, predict_take 1 and init_busy 1.
REQ-031 rst asserted mid-walk or in RUN SHALL restart the walk from address 0.
REQ-032 After rst deasserts, init_busy SHALL remain 1 for exactly 2^IDX_BITS cycles; only then are updates accepted.
REQ-033 Table contents SHALL be undefined until the walk completes; no reset fan-out to the array is required.

Verification
REQ-034 Reset then idle (defaults) -> init_busy=1 for 256 cycles then 0; predict_take=1 for any pc_cur; both counters read 0.
REQ-035 MODE=0, three taken=0 updates at pc_past=0x0000_0010 -> counter goes 2->1->0->0; lookup at pc_cur=0x10 yields predict_take=0 one cycle later.
REQ-036 MODE=1, pc 0x100 updated alternately taken=1/0 for 16 branches -> ghr follows the pattern; the two history-distinct indices saturate at 3 and 0, and predictions alternate correctly.
REQ-037 Same-cycle vld update taken=0 and lookup with same index, counter=2 -> predict_take=1 (old value); next lookup returns 0.
REQ-038 vld=1 during INIT with taken=1 -> ghr, resolve_cnt and mispred_cnt stay 0; rst pulsed at walk address 100 -> init_busy stays 1 for another 256 cycles.
REQ-039 10 updates, 4 with taken != pred_past -> resolve_cnt=10, mispred_cnt=4; counters preloaded near max saturate at 32'hFFFF_FFFF.
